// File: rtl/alu_pkg.sv
// ALU issue slice: shared constants, select enums and decode helper.
// Imported by alu_decode and alu_issue.
package alu_pkg;

  localparam int DEF_SIGNAL_WIDTH = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} asel_e;
  typedef enum logic [1:0] {B_RS2, B_IMM, B_ZERO} bsel_e;

  // Bit 1 = command slot full, bit 0 = result slot full.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_RES   = 2'b01,
    OCC_CMD   = 2'b10,
    OCC_BOTH  = 2'b11
  } occ_e;

  // alt selects SUB for funct3 000 and SRA for funct3 101.
  function automatic logic [3:0] f3_to_sel(input logic [2:0] f3,
                                           input logic alt);
    logic [3:0] s;
    unique case (f3)
      3'b000:  s = alt ? ALU_SUB : ALU_ADD;
      3'b001:  s = ALU_SLL;
      3'b010:  s = ALU_SLT;
      3'b011:  s = ALU_SLTU;
      3'b100:  s = ALU_XOR;
      3'b101:  s = alt ? ALU_SRA : ALU_SRL;
      3'b110:  s = ALU_OR;
      default: s = ALU_AND;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode: opcode/funct3/funct7b5 -> ALUSel, operand
// selects, shift flag (B trimmed to 5 bits) and illegal flag.
module alu_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] alusel_o,
  output asel_e      a_sel_o,
  output bsel_e      b_sel_o,
  output logic       shift_o,
  output logic       illegal_o
);

  logic is_sh;
  assign is_sh = (funct3_i == 3'b001) || (funct3_i == 3'b101);

  always_comb begin
    alusel_o  = ALU_ADD;
    a_sel_o   = A_ZERO;
    b_sel_o   = B_ZERO;
    shift_o   = 1'b0;
    illegal_o = 1'b0;
    unique case (1'b1)
      (opcode_i == OP_R): begin
        a_sel_o  = A_RS1;
        b_sel_o  = B_RS2;
        alusel_o = f3_to_sel(funct3_i, funct7b5_i);
        shift_o  = is_sh;
      end
      (opcode_i == OP_I): begin
        a_sel_o  = A_RS1;
        b_sel_o  = B_IMM;
        // No SUBI: alt only matters for the right shift.
        alusel_o = f3_to_sel(funct3_i,
                     funct7b5_i && (funct3_i == 3'b101));
        shift_o  = is_sh;
      end
      (opcode_i == OP_LUI): begin
        a_sel_o = A_ZERO;
        b_sel_o = B_IMM;
      end
      (opcode_i == OP_AUIPC): begin
        a_sel_o = A_PC;
        b_sel_o = B_IMM;
      end
      (opcode_i == OP_LOAD) || (opcode_i == OP_STORE): begin
        a_sel_o = A_RS1;
        b_sel_o = B_IMM;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Two-slot ALU issue pipeline (command reg -> result reg) around an
// external combinational ALU. Ports: in_* command handshake, ALUSel/
// alumux*_out to ALU, alu_out back, out_* result handshake, issue_count.
module alu_issue
  import alu_pkg::*;
#(
  parameter int SIGNAL_WIDTH = DEF_SIGNAL_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic                    funct7b5,
  input  logic [SIGNAL_WIDTH-1:0] rs1_data,
  input  logic [SIGNAL_WIDTH-1:0] rs2_data,
  input  logic [SIGNAL_WIDTH-1:0] imm,
  input  logic [SIGNAL_WIDTH-1:0] pc,
  input  logic [4:0]              rd,
  output logic [3:0]              ALUSel,
  output logic [SIGNAL_WIDTH-1:0] alumux1_out,
  output logic [SIGNAL_WIDTH-1:0] alumux2_out,
  input  logic [SIGNAL_WIDTH-1:0] alu_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SIGNAL_WIDTH-1:0] out_result,
  output logic [4:0]              out_rd,
  output logic                    out_illegal,
  output logic [15:0]             issue_count
);

  localparam int W = SIGNAL_WIDTH;

  logic [3:0] dec_sel;
  asel_e      dec_a;
  bsel_e      dec_b;
  logic       dec_sh;
  logic       dec_ill;

  alu_decode u_dec (
    .opcode_i   (opcode),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .alusel_o   (dec_sel),
    .a_sel_o    (dec_a),
    .b_sel_o    (dec_b),
    .shift_o    (dec_sh),
    .illegal_o  (dec_ill)
  );

  logic [W-1:0] a_src, b_raw, b_src;

  always_comb begin
    unique case (dec_a)
      A_RS1:   a_src = rs1_data;
      A_PC:    a_src = pc;
      default: a_src = '0;
    endcase
    unique case (dec_b)
      B_RS2:   b_raw = rs2_data;
      B_IMM:   b_raw = imm;
      default: b_raw = '0;
    endcase
    b_src = dec_sh ? {{(W-5){1'b0}}, b_raw[4:0]} : b_raw;
  end

  occ_e state_q, state_d;
  logic cmd_occ, res_occ, advance, accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= OCC_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    logic cmd_n, res_n;
    cmd_n   = accept || (cmd_occ && !advance);
    res_n   = advance || (res_occ && !out_ready);
    state_d = occ_e'({cmd_n, res_n});
  end

  always_comb begin
    cmd_occ   = state_q[1];
    res_occ   = state_q[0];
    advance   = cmd_occ && (!res_occ || out_ready);
    in_ready  = !cmd_occ || advance;
    accept    = in_valid && in_ready;
    out_valid = res_occ;
  end

  logic [3:0]   sel_q;
  logic [W-1:0] a_q, b_q, res_q;
  logic [4:0]   rd_q, res_rd_q;
  logic         ill_q, res_ill_q;
  logic [15:0]  cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= ALU_ADD;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      ill_q     <= 1'b0;
      res_q     <= '0;
      res_rd_q  <= '0;
      res_ill_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (advance) begin
        res_q     <= ill_q ? '0 : alu_out;
        res_rd_q  <= rd_q;
        res_ill_q <= ill_q;
      end
      if (accept) begin
        sel_q <= dec_sel;
        a_q   <= a_src;
        b_q   <= b_src;
        rd_q  <= rd;
        ill_q <= dec_ill;
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign ALUSel      = sel_q;
  assign alumux1_out = a_q;
  assign alumux2_out = b_q;
  assign out_result  = res_q;
  assign out_rd      = res_rd_q;
  assign out_illegal = res_ill_q;
  assign issue_count = cnt_q;

endmodule
